// File: rtl/clockbox_pkg.sv
// Shared definitions for the clock time-of-day controller.
//   set_state_t : controller state. The encoding is also the field_sel output
//                 (0 = none/RUN, 1 = hours, 2 = minutes, 3 = seconds).
//   DEF_*       : default field width and per-field wrap limits.
package clockbox_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    SET_HOURS   = 2'd1,
    SET_MINUTES = 2'd2,
    SET_SECONDS = 2'd3
  } set_state_t;

  localparam int DEF_FIELD_W  = 6;
  localparam int DEF_HOUR_MAX = 23;
  localparam int DEF_MIN_MAX  = 59;
  localparam int DEF_SEC_MAX  = 59;

endpackage

// File: rtl/Register.sv
// Generic enabled storage register with synchronous active-high reset to 0.
//   clk   : clock, state updates on posedge
//   reset : synchronous, active-high; clears q to 0
//   en    : load enable; q holds when low
//   d     : data in (WIDTH)
//   q     : data out (WIDTH)
module Register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wrap_step.sv
// Combinational modulo step of one time field.
//   value      : current field value (0..max_value)
//   max_value  : last legal value; increment from here wraps to 0
//   inc        : request +1
//   dec        : request -1 (0 wraps to max_value)
//   next_value : stepped value; inc and dec together cancel to no change
module wrap_step #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] max_value,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] next_value
);

  always_comb begin
    next_value = value;
    if (inc && !dec) begin
      next_value = (value == max_value) ? '0 : value + WIDTH'(1);
    end else if (dec && !inc) begin
      next_value = (value == '0) ? max_value : value - WIDTH'(1);
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Time-of-day controller: owns the hh:mm:ss registers, counts them from a
// 1 Hz tick in RUN, and lets the user adjust one field at a time in the
// SET_* states with inc/dec buttons (modulo wrap).
//   clock      : system clock, all state on posedge
//   reset      : synchronous, active-high
//   tick_1hz   : one-cycle pulse once per second
//   mode_btn   : debounced level; rising edge advances the state
//   inc_btn    : debounced level; rising edge increments the selected field
//   dec_btn    : debounced level; rising edge decrements the selected field
//   hours      : current hours   (FIELD_W)
//   minutes    : current minutes (FIELD_W)
//   seconds    : current seconds (FIELD_W)
//   set_active : 1 in any SET_* state
//   field_sel  : current state encoding (0 none, 1 hours, 2 minutes, 3 seconds)
//   blink      : blanking phase of the selected field, toggled by tick in SET_*
module time_set_controller
  import clockbox_pkg::*;
#(
  parameter int FIELD_W  = DEF_FIELD_W,
  parameter int HOUR_MAX = DEF_HOUR_MAX,
  parameter int MIN_MAX  = DEF_MIN_MAX,
  parameter int SEC_MAX  = DEF_SEC_MAX
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               mode_btn,
  input  logic               inc_btn,
  input  logic               dec_btn,
  output logic [FIELD_W-1:0] hours,
  output logic [FIELD_W-1:0] minutes,
  output logic [FIELD_W-1:0] seconds,
  output logic               set_active,
  output logic [1:0]         field_sel,
  output logic               blink
);

  localparam logic [FIELD_W-1:0] HOUR_LIM = FIELD_W'(HOUR_MAX);
  localparam logic [FIELD_W-1:0] MIN_LIM  = FIELD_W'(MIN_MAX);
  localparam logic [FIELD_W-1:0] SEC_LIM  = FIELD_W'(SEC_MAX);

  set_state_t state;

  // Button history resets to 1 so a button held through reset yields no
  // edge until it is released and pressed again.
  logic mode_prev, inc_prev, dec_prev;
  logic mode_edge, inc_edge, dec_edge;

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      dec_prev  <= 1'b1;
    end else begin
      mode_prev <= mode_btn;
      inc_prev  <= inc_btn;
      dec_prev  <= dec_btn;
    end
  end

  assign mode_edge = mode_btn & ~mode_prev;
  assign inc_edge  = inc_btn  & ~inc_prev;
  assign dec_edge  = dec_btn  & ~dec_prev;

  // Per-field step requests. In RUN the tick drives the full carry chain in
  // one cycle (and a coincident mode edge does not suppress it). In SET_*
  // a mode edge drops any inc/dec seen in the same cycle.
  logic hr_inc, hr_dec, min_inc, min_dec, sec_inc, sec_dec;

  always_comb begin
    hr_inc  = 1'b0;
    hr_dec  = 1'b0;
    min_inc = 1'b0;
    min_dec = 1'b0;
    sec_inc = 1'b0;
    sec_dec = 1'b0;
    if (state == RUN) begin
      if (tick_1hz) begin
        sec_inc = 1'b1;
        min_inc = (seconds == SEC_LIM);
        hr_inc  = (seconds == SEC_LIM) && (minutes == MIN_LIM);
      end
    end else if (!mode_edge) begin
      case (state)
        SET_HOURS: begin
          hr_inc = inc_edge;
          hr_dec = dec_edge;
        end
        SET_MINUTES: begin
          min_inc = inc_edge;
          min_dec = dec_edge;
        end
        SET_SECONDS: begin
          sec_inc = inc_edge;
          sec_dec = dec_edge;
        end
        default: ;
      endcase
    end
  end

  logic [FIELD_W-1:0] hr_next, min_next, sec_next;

  wrap_step #(.WIDTH(FIELD_W)) u_hr_step (
    .value(hours), .max_value(HOUR_LIM), .inc(hr_inc), .dec(hr_dec),
    .next_value(hr_next)
  );
  wrap_step #(.WIDTH(FIELD_W)) u_min_step (
    .value(minutes), .max_value(MIN_LIM), .inc(min_inc), .dec(min_dec),
    .next_value(min_next)
  );
  wrap_step #(.WIDTH(FIELD_W)) u_sec_step (
    .value(seconds), .max_value(SEC_LIM), .inc(sec_inc), .dec(sec_dec),
    .next_value(sec_next)
  );

  // Enable only when exactly one of inc/dec is requested; both together is
  // a no-change case, so the register is simply not loaded.
  Register #(.WIDTH(FIELD_W)) u_hours_reg (
    .clk(clock), .reset(reset), .en(hr_inc ^ hr_dec), .d(hr_next), .q(hours)
  );
  Register #(.WIDTH(FIELD_W)) u_minutes_reg (
    .clk(clock), .reset(reset), .en(min_inc ^ min_dec), .d(min_next), .q(minutes)
  );
  Register #(.WIDTH(FIELD_W)) u_seconds_reg (
    .clk(clock), .reset(reset), .en(sec_inc ^ sec_dec), .d(sec_next), .q(seconds)
  );

  // Mode FSM and blink phase. Every mode edge lands either in RUN or on
  // entry to a SET_* state, and both require blink = 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      blink <= 1'b0;
    end else if (mode_edge) begin
      blink <= 1'b0;
      case (state)
        RUN:         state <= SET_HOURS;
        SET_HOURS:   state <= SET_MINUTES;
        SET_MINUTES: state <= SET_SECONDS;
        SET_SECONDS: state <= RUN;
        default:     state <= RUN;
      endcase
    end else if (state == RUN) begin
      blink <= 1'b0;
    end else if (tick_1hz) begin
      blink <= ~blink;
    end
  end

  assign field_sel  = state;
  assign set_active = (state != RUN);

endmodule

// File: tb/tb_time_set_controller.sv
// Directed testbench for time_set_controller. Inputs change 1 ns after a
// rising edge and outputs are sampled 1 ns after the following rising edge.
module tb_time_set_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       dec_btn = 1'b0;
  logic [5:0] hours, minutes, seconds;
  logic       set_active, blink;
  logic [1:0] field_sel;

  int err_cnt = 0;
  int chk_cnt = 0;

  // clock/reset block
  always #5 clock = ~clock;

  time_set_controller dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz),
    .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .set_active(set_active), .field_sel(field_sel), .blink(blink)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press_mode();
    mode_btn = 1'b1; step(); mode_btn = 1'b0; step();
  endtask

  task automatic press_inc();
    inc_btn = 1'b1; step(); inc_btn = 1'b0; step();
  endtask

  task automatic press_dec();
    dec_btn = 1'b1; step(); dec_btn = 1'b0; step();
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_h"}, 32'(hours), 32'(h));
    check({tag, "_m"}, 32'(minutes), 32'(m));
    check({tag, "_s"}, 32'(seconds), 32'(s));
  endtask

  initial begin
    // Reset with mode held high, then keep it held: no edge may be seen.
    reset = 1'b1; mode_btn = 1'b1;
    step(); step();
    check_time("reset", 0, 0, 0);
    check("reset_sel", 32'(field_sel), 0);
    check("reset_blink", 32'(blink), 0);
    check("reset_set_active", 32'(set_active), 0);
    reset = 1'b0;
    repeat (5) step();
    check("held_mode_sel", 32'(field_sel), 0);

    // Release, then press: SET_HOURS visible one cycle after the press.
    mode_btn = 1'b0; step();
    mode_btn = 1'b1; step();
    check("press_sel_hours", 32'(field_sel), 1);
    check("press_set_active", 32'(set_active), 1);
    check("enter_blink", 32'(blink), 0);
    mode_btn = 1'b0; step();

    // Ticks toggle blink and leave time frozen.
    pulse_tick();
    check("blink_1", 32'(blink), 1);
    pulse_tick();
    check("blink_2", 32'(blink), 0);
    pulse_tick();
    check("blink_3", 32'(blink), 1);
    check_time("frozen", 0, 0, 0);

    // inc and dec together: no change.
    inc_btn = 1'b1; dec_btn = 1'b1; step();
    check("incdec_h", 32'(hours), 0);
    inc_btn = 1'b0; dec_btn = 1'b0; step();

    press_dec();
    check("hour_dec_wrap", 32'(hours), 23);
    press_inc();
    check("hour_inc_wrap", 32'(hours), 0);
    press_dec();
    check("hour_dec_again", 32'(hours), 23);

    // To SET_MINUTES: blink cleared on entry.
    press_mode();
    check("sel_minutes", 32'(field_sel), 2);
    check("min_entry_blink", 32'(blink), 0);
    press_dec();
    check_time("min_dec_wrap", 23, 59, 0);

    press_mode();
    check("sel_seconds", 32'(field_sel), 3);
    press_dec();
    check_time("sec_dec_wrap", 23, 59, 59);
    pulse_tick();
    check("sec_blink", 32'(blink), 1);

    // Back to RUN: blink forced low, fields kept.
    press_mode();
    check("run_sel", 32'(field_sel), 0);
    check("run_blink", 32'(blink), 0);
    check("run_set_active", 32'(set_active), 0);
    check_time("run_kept", 23, 59, 59);

    // inc/dec ignored in RUN.
    press_inc();
    press_dec();
    check_time("run_ignore_btn", 23, 59, 59);

    // Full carry chain in one cycle.
    tick_1hz = 1'b1; step();
    check_time("rollover", 0, 0, 0);
    tick_1hz = 1'b0; step();
    pulse_tick();
    check_time("count_1", 0, 0, 1);

    // Go to SET_SECONDS and set 58.
    press_mode(); press_mode(); press_mode();
    check("sel_seconds_2", 32'(field_sel), 3);
    press_dec(); press_dec(); press_dec();
    check("sec_58", 32'(seconds), 58);

    // Mode and inc together: mode wins.
    mode_btn = 1'b1; inc_btn = 1'b1; step();
    check("mode_wins_sel", 32'(field_sel), 0);
    check("mode_wins_s", 32'(seconds), 58);
    mode_btn = 1'b0; inc_btn = 1'b0; step();
    pulse_tick();
    check_time("count_from_set", 0, 0, 59);
    pulse_tick();
    check_time("min_carry", 0, 1, 0);

    // Mode edge with tick in RUN: tick applied, then SET_HOURS.
    mode_btn = 1'b1; tick_1hz = 1'b1; step();
    check("mode_tick_sel", 32'(field_sel), 1);
    check_time("mode_tick", 0, 1, 1);
    mode_btn = 1'b0; tick_1hz = 1'b0; step();

    // Reset mid-set.
    press_inc();
    check("pre_reset_h", 32'(hours), 1);
    reset = 1'b1; step();
    check("midreset_sel", 32'(field_sel), 0);
    check_time("midreset", 0, 0, 0);
    reset = 1'b0; step();

    // final report
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
